// File: rtl/parallel_to_serial_tx_if.sv
// Handshake/data bundle between a word source and the serial transmitter.
// The master drives start/data_in; the slave (transmitter) drives the serial side.
interface parallel_to_serial_tx_if #(
  parameter int DATA_W = 8
) ();

  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              sdo;
  logic              bit_strobe;
  logic              busy;
  logic              done;

  modport master (
    output start,
    output data_in,
    input  sdo,
    input  bit_strobe,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  data_in,
    output sdo,
    output bit_strobe,
    output busy,
    output done
  );

endinterface

// File: rtl/parallel_to_serial_tx.sv
// MSB-first parallel-to-serial transmitter; each bit is held CLK_DIV clocks.
// Optional macro TX_PARITY_EN appends one even-parity bit period after the data.
module parallel_to_serial_tx #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input logic                   clk,
  input logic                   rst,
  parallel_to_serial_tx_if.slave bus
);

`ifdef TX_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_W + 1) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] shift_reg;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              bit_end;

`ifdef TX_PARITY_EN
  logic              parity;
`endif

  assign bit_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_end && (bit_cnt == BIT_LAST)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Word capture and per-bit shifting; counters only advance while in SHIFT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_reg <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
`ifdef TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_reg <= bus.data_in;
            div_cnt   <= '0;
            bit_cnt   <= '0;
`ifdef TX_PARITY_EN
            parity    <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (bit_end) begin
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
            div_cnt   <= '0;
            bit_cnt   <= bit_cnt + BIT_W'(1);
`ifdef TX_PARITY_EN
            // Parity accumulates from the captured bits as they leave the register.
            parity    <= parity ^ shift_reg[DATA_W-1];
`endif
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    bus.sdo        = 1'b1;
    bus.bit_strobe = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    case (state)
      SHIFT: begin
        bus.busy       = 1'b1;
        bus.bit_strobe = bit_end;
`ifdef TX_PARITY_EN
        bus.sdo        = (bit_cnt == BIT_LAST) ? parity : shift_reg[DATA_W-1];
`else
        bus.sdo        = shift_reg[DATA_W-1];
`endif
      end
      DONE: begin
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// Directed self-checking bench for parallel_to_serial_tx (CLK_DIV=4 and CLK_DIV=1).
// Honours TX_PARITY_EN by expecting the extra parity bit period.
module tb_parallel_to_serial_tx;

  localparam int DIV = 4;
`ifdef TX_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  parallel_to_serial_tx_if #(.DATA_W(8)) bus ();
  parallel_to_serial_tx_if #(.DATA_W(8)) fbus ();

  parallel_to_serial_tx #(.DATA_W(8), .CLK_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  parallel_to_serial_tx #(.DATA_W(8), .CLK_DIV(1)) dut_fast (
    .clk (clk),
    .rst (rst),
    .bus (fbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic expBit(logic [7:0] w, int b);
    if (b < 8) return w[7-b];
    return ^w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(logic s, logic [7:0] d);
    bus.start   = s;
    bus.data_in = d;
  endtask

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBus(string tag, logic s, logic b, logic st, logic d);
    checkOutput({tag, " sdo"}, 32'(bus.sdo), 32'(s));
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'(b));
    checkOutput({tag, " strobe"}, 32'(bus.bit_strobe), 32'(st));
    checkOutput({tag, " done"}, 32'(bus.done), 32'(d));
  endtask

  // Full transfer: start for one edge, then scramble data_in to prove capture.
  task automatic runTransfer(logic [7:0] word, string tag);
    applyStimulus(1'b1, word);
    tick();
    applyStimulus(1'b0, ~word);
    for (int i = 0; i < NB * DIV; i++) begin
      checkBus($sformatf("%s c%0d", tag, i + 1), expBit(word, i / DIV), 1'b1,
               (i % DIV) == DIV - 1, 1'b0);
      tick();
    end
    checkBus({tag, " donecycle"}, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    checkBus({tag, " after"}, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00);
    fbus.start   = 1'b0;
    fbus.data_in = 8'h00;
    repeat (3) tick();
    checkBus("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkBus($sformatf("idle %0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
    end

    runTransfer(8'hA5, "a5");
    runTransfer(8'h07, "07");

    // start held high: second accept only after the DONE cycle
    applyStimulus(1'b1, 8'h3C);
    tick();
    for (int i = 0; i < NB * DIV; i++) begin
      checkBus($sformatf("hold c%0d", i + 1), expBit(8'h3C, i / DIV), 1'b1,
               (i % DIV) == DIV - 1, 1'b0);
      tick();
    end
    checkBus("hold donecycle", 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    checkBus("hold gap", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkBus("hold restart", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00);
    n = 0;
    while (!bus.done && n < 500) begin
      tick();
      n++;
    end
    checkOutput("hold second done latency", 32'(n), 32'(NB * DIV));
    tick();
    checkBus("hold idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // reset mid-transfer
    applyStimulus(1'b1, 8'hFF);
    tick();
    applyStimulus(1'b0, 8'h00);
    repeat (12) tick();
    checkBus("midrst before", 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    checkBus("midrst after", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checkOutput($sformatf("midrst nodone %0d", i), 32'(bus.done | bus.busy), 32'd0);
    end
    runTransfer(8'h01, "01");

    // CLK_DIV=1 instance
    fbus.start   = 1'b1;
    fbus.data_in = 8'h80;
    tick();
    fbus.start   = 1'b0;
    fbus.data_in = 8'hFF;
    for (int i = 0; i < NB; i++) begin
      checkOutput($sformatf("fast sdo %0d", i), 32'(fbus.sdo), 32'(expBit(8'h80, i)));
      checkOutput($sformatf("fast strobe %0d", i), 32'(fbus.bit_strobe), 32'd1);
      checkOutput($sformatf("fast busy %0d", i), 32'(fbus.busy), 32'd1);
      checkOutput($sformatf("fast done %0d", i), 32'(fbus.done), 32'd0);
      tick();
    end
    checkOutput("fast donecycle", 32'(fbus.done), 32'd1);
    checkOutput("fast donecycle busy", 32'(fbus.busy), 32'd0);
    checkOutput("fast donecycle sdo", 32'(fbus.sdo), 32'd1);
    tick();
    checkOutput("fast after done", 32'(fbus.done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parallel_to_serial_tx.md
Name: parallel_to_serial_tx

Overview:
- Parallel-in, serial-out transmitter. It is the writer end of the serial link whose receiver is a chain of D flip-flops clocked by the sample strobe.
- Captures a DATA_W-bit word on a start request and shifts it out MSB-first on sdo.
- Each bit is held for CLK_DIV clock cycles; a one-cycle strobe marks each bit's sample point.
- Completion is reported with a one-cycle done pulse.

Parameters:
- DATA_W, 8: word width in bits (≥2).
- CLK_DIV, 4: clk cycles per serial bit (≥1).

Ports:
- clk  input  1  system clock; all logic on posedge clk.
- rst  input  1  one clock; reset is synchronous and active-low (rst=0 resets on the next posedge clk).
- start  input  1  transfer request; sampled only in IDLE.
- data_in  input  DATA_W  word to send; captured on the accepting edge.
- sdo  output  1  serial data; idles high.
- bit_strobe  output  1  high in the last cycle of each bit period (receiver sample point).
- busy  output  1  high while bits are being shifted.
- done  output  1  one-cycle pulse after the last bit period.

Behaviour:
- Reset (rst=0 at a posedge): state=IDLE, sdo=1, busy=0, done=0, bit_strobe=0, counters=0, shift register=0. Reset mid-transfer aborts; no done pulse is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - sdo=1, busy=0.
  - start=1 at edge k: load shift_reg<=data_in, bit_cnt<=0, div_cnt<=0, go to SHIFT.
  - From cycle k+1: busy=1 and sdo=data_in[DATA_W-1].
- SHIFT:
  - sdo = shift_reg MSB.
  - div_cnt counts 0..CLK_DIV-1; bit_strobe=1 when div_cnt==CLK_DIV-1.
  - On a strobe cycle: shift left by 1, bit_cnt++, div_cnt<=0.
  - On the strobe of bit DATA_W-1: go to DONE.
- DONE:
  - Lasts exactly 1 cycle: done=1, busy=0, sdo=1. Then return to IDLE.
- Timing:
  - busy is high for exactly DATA_W*CLK_DIV cycles (k+1 .. k+DATA_W*CLK_DIV).
  - done is high at cycle k+DATA_W*CLK_DIV+1.
  - The earliest next accepting edge is k+DATA_W*CLK_DIV+2.
- Inputs outside IDLE:
  - start is ignored in SHIFT and DONE; there is no queuing.
  - data_in changes after capture have no effect.
- CLK_DIV=1: bit_strobe is high every SHIFT cycle; one bit per cycle.
- Counter widths: div_cnt is $clog2(CLK_DIV)+1 bits; bit_cnt is $clog2(DATA_W+1)+1 bits. No wrap occurs within a legal transfer.
- Outputs are registered or decoded from registered state only; no combinational path from start or data_in to any output.

Optional Feature:
- Macro: TX_PARITY_EN.
- Defined:
  - After the DATA_W data bits, one extra bit period carries even parity: XOR of the captured word.
  - This bit has its own bit_strobe.
  - busy lasts (DATA_W+1)*CLK_DIV cycles; done shifts one bit period later.
  - The parity bit is computed from the captured copy, not the live data_in.
- Not defined: exactly DATA_W bit periods, with no parity logic synthesized.

Test Plan:
- Reset, then idle 10 cycles with start=0: sdo=1, busy=0, done=0, bit_strobe=0 throughout.
- DATA_W=8, CLK_DIV=4, start pulse with data_in=8'hA5 at edge k:
  - sdo = 1,0,1,0,0,1,0,1, each held 4 cycles over k+1..k+32.
  - bit_strobe at k+4, k+8, ..., k+32 (8 pulses).
  - busy high for 32 cycles; done=1 only at k+33.
- Start held high continuously with data_in=8'h3C:
  - First word is sent.
  - start is ignored during SHIFT and DONE.
  - The second transfer begins with the edge at k+34 (busy rises at k+35).
  - No overlap, and sdo=1 during the DONE cycle.
- Reset mid-transfer: rst=0 at k+13 during 8'hFF:
  - Next cycle: sdo=1, busy=0, no done pulse.
  - A new start of 8'h01 after reset is sent correctly.
- CLK_DIV=1, data 8'h80: sdo=1 for 1 cycle, then 0 for 7 cycles; bit_strobe high for 8 consecutive cycles; done at k+9.
- With TX_PARITY_EN, CLK_DIV=4:
  - 8'hA5 gives parity bit 0; 8'h07 gives parity bit 1, held at k+33..k+36.
  - busy lasts 36 cycles; done at k+37.
